// File: rtl/dmem_io_arbiter.sv
// Data-memory port arbiter: the CPU owns the single 64-bit port except while the
// I/O refresh sequencer writes the switches word and reads the LED word.
module dmem_io_arbiter #(
  parameter int unsigned REFRESH_CYCLES = 1024,
  parameter int unsigned MAX_DEFER      = 8,
  parameter int unsigned SWITCH_ADDR    = 21,
  parameter int unsigned LED_ADDR       = 22
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [63:0] i_cpu_address,
  input  logic [63:0] i_cpu_write_data,
  input  logic        i_cpu_mem_write,
  input  logic        i_cpu_mem_read,
  output logic [63:0] o_cpu_read_data,
  output logic        o_cpu_stall,
  input  logic [17:0] i_switches,
  output logic [26:0] o_leds,
  output logic [63:0] o_mem_address,
  output logic [63:0] o_mem_write_data,
  output logic        o_mem_write,
  output logic        o_mem_read,
  input  logic [63:0] i_mem_read_data
);

  localparam int unsigned CntW = (REFRESH_CYCLES < 4) ? 2 : $clog2(REFRESH_CYCLES);
  localparam int unsigned DefW = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_CYCLES - 1);
  localparam logic [DefW-1:0] DefMax  = DefW'(MAX_DEFER);
  localparam logic [63:0]     SwAddr  = 64'(SWITCH_ADDR);
  localparam logic [63:0]     LedAddr = 64'(LED_ADDR);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSwWrite = 2'd1,
    StLedRead = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [17:0]     r_sw_meta;
  logic [17:0]     r_sw_sync;
  logic [CntW-1:0] r_refresh_cnt;
  logic [CntW-1:0] w_refresh_cnt_next;
  logic            w_refresh_tc;
  logic            r_io_pending;
  logic            w_io_pending_next;
  logic [DefW-1:0] r_defer_cnt;
  logic [DefW-1:0] w_defer_next;
  logic [26:0]     r_leds;
  logic [26:0]     w_leds_next;
  logic            w_cpu_req;

  assign w_cpu_req = i_cpu_mem_read | i_cpu_mem_write;
  assign o_leds    = r_leds;

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_switches;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= StIdle;
      r_refresh_cnt <= '0;
      r_io_pending  <= 1'b0;
      r_defer_cnt   <= '0;
      r_leds        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_refresh_cnt <= w_refresh_cnt_next;
      r_io_pending  <= w_io_pending_next;
      r_defer_cnt   <= w_defer_next;
      r_leds        <= w_leds_next;
    end
  end

  // The refresh timer free-runs through service so the refresh period stays fixed.
  always_comb begin
    w_refresh_tc       = (r_refresh_cnt == CntLast);
    w_refresh_cnt_next = w_refresh_tc ? '0 : r_refresh_cnt + CntW'(1);
  end

  // Sticky request; a terminal count landing on the LED_READ edge must not be lost.
  always_comb begin
    w_io_pending_next = r_io_pending;
    if (r_state == StLedRead) begin
      w_io_pending_next = 1'b0;
    end
    if (w_refresh_tc) begin
      w_io_pending_next = 1'b1;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_defer_next     = r_defer_cnt;
    w_leds_next      = r_leds;
    o_mem_address    = '0;
    o_mem_write_data = '0;
    o_mem_write      = 1'b0;
    o_mem_read       = 1'b0;
    o_cpu_read_data  = '0;
    o_cpu_stall      = 1'b0;

    unique case (r_state)
      StIdle: begin
        o_mem_address    = i_cpu_address;
        o_mem_write_data = i_cpu_write_data;
        o_mem_read       = i_cpu_mem_read;
        // The switch word belongs to the sequencer; CPU stores to it are dropped.
        o_mem_write      = i_cpu_mem_write && (i_cpu_address != SwAddr);
        o_cpu_read_data  = i_cpu_mem_read ? i_mem_read_data : '0;

        if (r_io_pending && w_cpu_req && (r_defer_cnt != DefMax)) begin
          w_defer_next = r_defer_cnt + DefW'(1);
        end
        // The CPU access of this deciding cycle still completes on the port.
        if (r_io_pending && (!w_cpu_req || (r_defer_cnt == DefMax))) begin
          w_state_next = StSwWrite;
        end
      end

      StSwWrite: begin
        o_mem_address    = SwAddr;
        o_mem_write_data = {46'b0, r_sw_sync};
        o_mem_write      = 1'b1;
        o_cpu_stall      = w_cpu_req;
        w_state_next     = StLedRead;
      end

      StLedRead: begin
        o_mem_address = LedAddr;
        o_mem_read    = 1'b1;
        o_cpu_stall   = w_cpu_req;
        w_leds_next   = i_mem_read_data[26:0];
        w_defer_next  = '0;
        w_state_next  = StIdle;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  a_stall_only_in_service: assert property (
    @(posedge i_clock) disable iff (!i_reset_n) o_cpu_stall |-> (r_state != StIdle)
  );

  a_switch_word_protected: assert property (
    @(posedge i_clock) disable iff (!i_reset_n)
    (o_mem_write && (o_mem_address == SwAddr)) |-> (r_state == StSwWrite)
  );

  a_defer_bounded: assert property (
    @(posedge i_clock) disable iff (!i_reset_n) r_defer_cnt <= DefMax
  );

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// Bench for dmem_io_arbiter: instance A (16-cycle refresh, defer 4) with a memory model,
// instance B (4-cycle refresh, defer 5) for the coincident-terminal-count corner.
module tb_dmem_io_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [17:0] switches;

  logic [63:0] a_cpu_address, a_cpu_write_data, a_cpu_read_data;
  logic        a_cpu_mem_write, a_cpu_mem_read, a_cpu_stall;
  logic [26:0] a_leds;
  logic [63:0] a_mem_address, a_mem_write_data, a_mem_read_data;
  logic        a_mem_write, a_mem_read;

  logic [63:0] b_cpu_address, b_cpu_write_data, b_cpu_read_data;
  logic        b_cpu_mem_write, b_cpu_mem_read, b_cpu_stall;
  logic [26:0] b_leds;
  logic [63:0] b_mem_address, b_mem_write_data, b_mem_read_data;
  logic        b_mem_write, b_mem_read;

  localparam logic [63:0] BRead = 64'h0000_0000_0123_4567;
  assign b_mem_read_data = BRead;

  logic [63:0] mem_a [64] = '{default: '0};
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [63:0] pre_data;

  assign a_mem_read_data = mem_a[a_mem_address[5:0]];

  always @(posedge clk) begin
    if (pre_we) mem_a[pre_addr] <= pre_data;
    else if (a_mem_write) mem_a[a_mem_address[5:0]] <= a_mem_write_data;
  end

  dmem_io_arbiter #(
    .REFRESH_CYCLES(16),
    .MAX_DEFER     (4),
    .SWITCH_ADDR   (21),
    .LED_ADDR      (22)
  ) u_dut_a (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_cpu_address   (a_cpu_address),
    .i_cpu_write_data(a_cpu_write_data),
    .i_cpu_mem_write (a_cpu_mem_write),
    .i_cpu_mem_read  (a_cpu_mem_read),
    .o_cpu_read_data (a_cpu_read_data),
    .o_cpu_stall     (a_cpu_stall),
    .i_switches      (switches),
    .o_leds          (a_leds),
    .o_mem_address   (a_mem_address),
    .o_mem_write_data(a_mem_write_data),
    .o_mem_write     (a_mem_write),
    .o_mem_read      (a_mem_read),
    .i_mem_read_data (a_mem_read_data)
  );

  dmem_io_arbiter #(
    .REFRESH_CYCLES(4),
    .MAX_DEFER     (5),
    .SWITCH_ADDR   (21),
    .LED_ADDR      (22)
  ) u_dut_b (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_cpu_address   (b_cpu_address),
    .i_cpu_write_data(b_cpu_write_data),
    .i_cpu_mem_write (b_cpu_mem_write),
    .i_cpu_mem_read  (b_cpu_mem_read),
    .o_cpu_read_data (b_cpu_read_data),
    .o_cpu_stall     (b_cpu_stall),
    .i_switches      (switches),
    .o_leds          (b_leds),
    .o_mem_address   (b_mem_address),
    .o_mem_write_data(b_mem_write_data),
    .o_mem_write     (b_mem_write),
    .o_mem_read      (b_mem_read),
    .i_mem_read_data (b_mem_read_data)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [63:0] got);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  // Waits for the next switch-word write bus cycle; reports its edge index and stalls seen.
  task automatic wait_sw(input bit sel_b, input int bound, output int at, output int stalls);
    bit found;
    bit hit;
    found  = 1'b0;
    at     = 0;
    stalls = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (sel_b) begin
        if (b_cpu_stall) stalls++;
        hit = b_mem_write && (b_mem_address == 64'd21);
      end else begin
        if (a_cpu_stall) stalls++;
        hit = a_mem_write && (a_mem_address == 64'd21);
      end
      if (hit) begin
        found = 1'b1;
        at    = cyc;
      end
    end
    if (!found) check(sel_b ? "b_sw_timeout" : "a_sw_timeout", 64'(found), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, prev, rel, st, s;
    logic [63:0] led_word;
    logic [17:0] sw_val;

    led_word = 64'h5_ABCD_EF01;
    sw_val   = 18'h2A5A5;
    rst_n    = 1'b0;
    switches = sw_val;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    a_cpu_address = '0; a_cpu_write_data = '0; a_cpu_mem_write = 1'b0; a_cpu_mem_read = 1'b0;
    b_cpu_address = '0; b_cpu_write_data = '0; b_cpu_mem_write = 1'b0; b_cpu_mem_read = 1'b0;

    @(negedge clk);
    pre_we = 1'b1; pre_addr = 6'd22; pre_data = led_word;
    @(negedge clk);
    pre_we = 1'b0;
    check("rst_leds", 64'(a_leds), 64'd0);
    check("rst_stall", 64'(a_cpu_stall), 64'd0);
    check("rst_mem_ctl", 64'({a_mem_write, a_mem_read}), 64'd0);
    check("rst_mem_addr", a_mem_address, 64'd0);

    // Basic refresh after release.
    rst_n = 1'b1;
    rel = cyc;
    exp_q.push_back(64'(led_word[26:0]));
    wait_sw(1'b0, 40, at, st);
    check("first_sw_delay", 64'(at - rel), 64'd17);
    check("sw_wdata", a_mem_write_data, {46'b0, sw_val});
    check("sw_stall", 64'(a_cpu_stall), 64'd0);
    @(negedge clk);
    check("mem21_written", mem_a[21], {46'b0, sw_val});
    check("led_rd_ctl", 64'({a_mem_read, a_mem_write}), 64'd2);
    check("led_rd_addr", a_mem_address, 64'd22);
    check("leds_before_edge", 64'(a_leds), 64'd0);
    @(negedge clk);
    check_pop("leds_refresh", 64'(a_leds));

    prev = at;
    wait_sw(1'b0, 40, at, st);
    check("refresh_period", 64'(at - prev), 64'd16);
    check("refresh_nostall", 64'(st), 64'd0);
    @(negedge clk);
    @(negedge clk);

    // CPU passthrough, switch-word protection, CPU write of the LED word.
    a_cpu_address = 64'd5; a_cpu_write_data = 64'hDEAD; a_cpu_mem_write = 1'b1;
    #1;
    check("st_we", 64'(a_mem_write), 64'd1);
    check("st_stall", 64'(a_cpu_stall), 64'd0);
    @(negedge clk);
    a_cpu_mem_write = 1'b0; a_cpu_mem_read = 1'b1;
    exp_q.push_back(64'hDEAD);
    #1;
    check_pop("ld_data", a_cpu_read_data);
    check("ld_stall", 64'(a_cpu_stall), 64'd0);
    @(negedge clk);
    a_cpu_mem_read = 1'b0; a_cpu_address = 64'd21; a_cpu_write_data = 64'hFFFF;
    a_cpu_mem_write = 1'b1;
    #1;
    check("prot_we", 64'(a_mem_write), 64'd0);
    @(negedge clk);
    check("prot_mem21", mem_a[21], {46'b0, sw_val});
    a_cpu_address = 64'd22; a_cpu_write_data = 64'h7FF_FFFF;
    #1;
    check("led_st_we", 64'(a_mem_write), 64'd1);
    @(negedge clk);
    a_cpu_mem_write = 1'b0; a_cpu_address = '0; a_cpu_write_data = '0;
    check("leds_hold", 64'(a_leds), 64'(led_word[26:0]));
    exp_q.push_back(64'h7FF_FFFF);
    wait_sw(1'b0, 40, at, st);
    @(negedge clk);
    check("leds_hold_led_read", 64'(a_leds), 64'(led_word[26:0]));
    @(negedge clk);
    check_pop("leds_cpu_word", 64'(a_leds));

    // Starvation guard: continuous CPU loads.
    a_cpu_address = 64'd5; a_cpu_mem_read = 1'b1;
    prev = at;
    wait_sw(1'b0, 40, at, st);
    check("defer_delay", 64'(at - prev), 64'd20);
    check("defer_stall_sw", 64'(st), 64'd1);
    check("defer_rd_masked", a_cpu_read_data, 64'd0);
    @(negedge clk);
    check("defer_stall_led", 64'(a_cpu_stall), 64'd1);
    @(negedge clk);
    check("defer_stall_release", 64'(a_cpu_stall), 64'd0);
    exp_q.push_back(64'hDEAD);
    check_pop("defer_ld", a_cpu_read_data);
    prev = at;
    wait_sw(1'b0, 40, at, st);
    check("defer_rearm", 64'(at - prev), 64'd16);
    check("defer_stall_sw2", 64'(st), 64'd1);
    @(negedge clk);
    @(negedge clk);
    a_cpu_mem_read = 1'b0; a_cpu_address = '0;

    // Reset asserted in the middle of LED_READ.
    wait_sw(1'b0, 40, at, st);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_leds", 64'(a_leds), 64'd0);
    check("midrst_stall", 64'(a_cpu_stall), 64'd0);
    check("midrst_mem_ctl", 64'({a_mem_write, a_mem_read}), 64'd0);
    check("midrst_mem_addr", a_mem_address, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    exp_q.push_back(64'h7FF_FFFF);
    wait_sw(1'b0, 40, at, st);
    check("rst_sw_delay", 64'(at - rel), 64'd17);
    @(negedge clk);
    @(negedge clk);
    check_pop("leds_after_rst", 64'(a_leds));

    // Instance B: terminal count on the LED_READ edge, absorbed terminal count while deferred.
    wait_sw(1'b1, 20, at, st);
    s = at;
    b_cpu_address = 64'd5; b_cpu_mem_read = 1'b1;
    wait_sw(1'b1, 20, at, st);
    check("b_coincide_delay", 64'(at - s), 64'd9);
    check("b_sw_stall", 64'(b_cpu_stall), 64'd1);
    check("b_sw_no_read", 64'(b_mem_read), 64'd0);
    check("b_sw_wdata", b_mem_write_data, {46'b0, sw_val});
    check("b_rd_masked", b_cpu_read_data, 64'd0);
    prev = at;
    @(negedge clk);
    @(negedge clk);
    check("b_leds", 64'(b_leds), 64'(BRead[26:0]));
    check("b_idle_ld", b_cpu_read_data, BRead);
    check("b_idle_stall", 64'(b_cpu_stall), 64'd0);
    b_cpu_mem_read = 1'b0;
    wait_sw(1'b1, 10, at, st);
    check("b_pending_kept", 64'(at - prev), 64'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
